// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

   localparam int XLEN = 32;

   localparam logic [31:0] INSTR_NOP     = 32'h0000_0013;
   localparam logic [31:0] ROM_BASE_WORD = 32'hA000_0000;

   typedef struct packed {
      logic [31:0]     instr;
      logic [XLEN-1:0] pc;
   } fetch_entry_t;

   // Built-in ROM image: word i holds ROM_BASE_WORD + i.
   function automatic logic [31:0] rom_word(input logic [31:0] word_idx);
      return ROM_BASE_WORD + word_idx;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries; flush clears it and wins over push/pop.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  fetch_entry_t push_entry,
   input  logic         pop,
   input  logic         flush,
   output logic         full,
   output logic         empty,
   output fetch_entry_t head
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   fetch_entry_t     mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             do_push, do_pop;

   assign full  = (count_q == (PTR_W+1)'(DEPTH));
   assign empty = (count_q == '0);
   assign head  = mem_q[rd_ptr_q];

   always_comb begin
      do_pop   = pop & ~empty & ~flush;
      do_push  = push & (~full | do_pop) & ~flush;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset; contents are only observed behind count_q.
   always_ff @(posedge clk) begin
      if (!reset && do_push) mem_q[wr_ptr_q] <= push_entry;
   end

endmodule

// File: rtl/fetch_queue_unit.sv
// Fetch engine: PC register, instruction ROM, decoupling queue toward decode, redirect handling.
module fetch_queue_unit
   import fetch_pkg::*;
#(
   parameter int              XLEN        = fetch_pkg::XLEN,
   parameter int              IMEM_DEPTH  = 64,
   parameter int              QUEUE_DEPTH = 4,
   parameter logic [XLEN-1:0] RESET_PC    = '0,
   parameter string           MEM_FILE    = "instr.mem"
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            Redirect,
   input  logic [XLEN-1:0] RedirectAddr,
   input  logic            Instr_ready,
   output logic            Instr_valid,
   output logic [31:0]     Instr,
   output logic [XLEN-1:0] PC_current,
   output logic [XLEN-1:0] PC_add4,
   output logic [15:0]     Redirect_count
);

   localparam int IDX_W = $clog2(IMEM_DEPTH);

   // ROM image comes from rom_word(); the file name is kept so file-loaded builds share this port map.
   localparam bit unused_mem_file = (MEM_FILE != "");

   logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
   logic [15:0]      redirect_count_q, redirect_count_d;
   logic [IDX_W-1:0] rom_idx;
   logic [31:0]      rom_instr;
   logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
   fetch_entry_t     push_entry, fifo_head;
   logic             unused_redirect_lsb;

   assign unused_redirect_lsb = ^RedirectAddr[1:0];

   assign rom_idx   = fetch_pc_q[IDX_W+1:2];
   assign rom_instr = rom_word({{(32-IDX_W){1'b0}}, rom_idx});

   always_comb begin
      fifo_pop         = ~fifo_empty & Instr_ready & ~Redirect;
      fifo_push        = ~Redirect & (~fifo_full | fifo_pop);
      push_entry.instr = rom_instr;
      push_entry.pc    = fetch_pc_q;
      fetch_pc_d       = fetch_pc_q;
      redirect_count_d = redirect_count_q;
      if (Redirect) begin
         fetch_pc_d = {RedirectAddr[XLEN-1:2], 2'b00};
         if (redirect_count_q != 16'hFFFF) redirect_count_d = redirect_count_q + 16'd1;
      end else if (fifo_push) begin
         fetch_pc_d = fetch_pc_q + XLEN'(4);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc_q       <= RESET_PC;
         redirect_count_q <= '0;
      end else begin
         fetch_pc_q       <= fetch_pc_d;
         redirect_count_q <= redirect_count_d;
      end
   end

   fetch_fifo #(
      .DEPTH (QUEUE_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (fifo_push),
      .push_entry (push_entry),
      .pop        (fifo_pop),
      .flush      (Redirect),
      .full       (fifo_full),
      .empty      (fifo_empty),
      .head       (fifo_head)
   );

   // Head outputs are forced to zero while the queue is empty rather than showing stale data.
   assign Instr_valid    = ~fifo_empty;
   assign Instr          = fifo_empty ? 32'd0 : fifo_head.instr;
   assign PC_current     = fifo_empty ? '0 : fifo_head.pc;
   assign PC_add4        = fifo_empty ? '0 : fifo_head.pc + XLEN'(4);
   assign Redirect_count = redirect_count_q;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed vector table plus randomized run against a queue-based reference model.
module tb_fetch_queue_unit;

   localparam int IMEM_DEPTH  = 64;
   localparam int QUEUE_DEPTH = 4;
   localparam logic [31:0] RESET_PC = 32'h0;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        Redirect = 1'b0;
   logic [31:0] RedirectAddr = '0;
   logic        Instr_ready = 1'b0;
   logic        Instr_valid;
   logic [31:0] Instr, PC_current, PC_add4;
   logic [15:0] Redirect_count;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   fetch_queue_unit #(
      .XLEN        (32),
      .IMEM_DEPTH  (IMEM_DEPTH),
      .QUEUE_DEPTH (QUEUE_DEPTH),
      .RESET_PC    (RESET_PC),
      .MEM_FILE    ("instr.mem")
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .Redirect       (Redirect),
      .RedirectAddr   (RedirectAddr),
      .Instr_ready    (Instr_ready),
      .Instr_valid    (Instr_valid),
      .Instr          (Instr),
      .PC_current     (PC_current),
      .PC_add4        (PC_add4),
      .Redirect_count (Redirect_count)
   );

   // Reference model: queue of {instr, pc}, a fetch address and a redirect tally.
   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
   } ment_t;

   ment_t       mq[$];
   logic [31:0] m_pc  = RESET_PC;
   logic [15:0] m_cnt = '0;

   function automatic logic [31:0] rom_of(input logic [31:0] addr);
      return 32'hA000_0000 + ((addr / 4) % IMEM_DEPTH);
   endfunction

   task automatic model_update();
      if (reset) begin
         mq.delete();
         m_pc  = RESET_PC;
         m_cnt = '0;
      end else if (Redirect) begin
         mq.delete();
         m_pc = RedirectAddr & ~32'h3;
         if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end else begin
         if (mq.size() > 0 && Instr_ready) void'(mq.pop_front());
         if (mq.size() < QUEUE_DEPTH) begin
            mq.push_back('{instr: rom_of(m_pc), pc: m_pc});
            m_pc = m_pc + 32'd4;
         end
      end
   endtask

   task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   typedef struct {
      bit          rst;
      bit          redir;
      logic [31:0] addr;
      bit          rdy;
      bit          e_valid;
      logic [31:0] e_pc;
      logic [31:0] e_instr;
      logic [15:0] e_cnt;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input bit rst, input bit redir, input logic [31:0] addr, input bit rdy,
                      input bit e_valid, input logic [31:0] e_pc, input logic [31:0] e_instr,
                      input logic [15:0] e_cnt);
      vecs.push_back('{rst, redir, addr, rdy, e_valid, e_pc, e_instr, e_cnt});
   endtask

   initial begin
      // rst redir addr  rdy | valid pc  instr  cnt
      add(1, 0, 0,   1,  0, 0,   32'h0,         0);
      add(1, 0, 0,   1,  0, 0,   32'h0,         0);
      add(0, 0, 0,   1,  1, 0,   32'hA000_0000, 0);
      add(0, 0, 0,   0,  1, 0,   32'hA000_0000, 0);
      add(0, 0, 0,   0,  1, 0,   32'hA000_0000, 0);
      add(0, 0, 0,   0,  1, 0,   32'hA000_0000, 0);
      add(0, 0, 0,   0,  1, 0,   32'hA000_0000, 0);
      add(0, 0, 0,   1,  1, 4,   32'hA000_0001, 0);
      add(0, 0, 0,   1,  1, 8,   32'hA000_0002, 0);
      add(0, 0, 0,   1,  1, 12,  32'hA000_0003, 0);
      add(0, 0, 0,   1,  1, 16,  32'hA000_0004, 0);
      add(0, 0, 0,   1,  1, 20,  32'hA000_0005, 0);
      add(0, 1, 12,  1,  0, 0,   32'h0,         1);
      add(0, 0, 0,   1,  1, 12,  32'hA000_0003, 1);
      add(0, 0, 0,   1,  1, 16,  32'hA000_0004, 1);
      add(0, 1, 32'h17, 1, 0, 0, 32'h0,         2);
      add(0, 0, 0,   1,  1, 20,  32'hA000_0005, 2);
      add(0, 1, IMEM_DEPTH*4+8, 1, 0, 0, 32'h0, 3);
      add(0, 0, 0,   0,  1, IMEM_DEPTH*4+8, 32'hA000_0002, 3);
      add(0, 0, 0,   0,  1, IMEM_DEPTH*4+8, 32'hA000_0002, 3);
      add(0, 0, 0,   0,  1, IMEM_DEPTH*4+8, 32'hA000_0002, 3);
      add(0, 0, 0,   0,  1, IMEM_DEPTH*4+8, 32'hA000_0002, 3);
      add(0, 1, 0,   1,  0, 0,   32'h0,         4);
      add(0, 0, 0,   0,  1, 0,   32'hA000_0000, 4);
      add(0, 0, 0,   0,  1, 0,   32'hA000_0000, 4);
      add(1, 0, 0,   1,  0, 0,   32'h0,         0);
      add(0, 0, 0,   1,  1, 0,   32'hA000_0000, 0);
      add(0, 0, 0,   1,  1, 4,   32'hA000_0001, 0);

      @(negedge clk);
      for (int i = 0; i < vecs.size(); i++) begin
         reset        = vecs[i].rst;
         Redirect     = vecs[i].redir;
         RedirectAddr = vecs[i].addr;
         Instr_ready  = vecs[i].rdy;
         step();
         chk("vec_valid",   i, {31'd0, Instr_valid}, {31'd0, vecs[i].e_valid});
         chk("vec_pc",      i, PC_current, vecs[i].e_pc);
         chk("vec_instr",   i, Instr, vecs[i].e_instr);
         chk("vec_pc_add4", i, PC_add4, vecs[i].e_valid ? vecs[i].e_pc + 32'd4 : 32'd0);
         chk("vec_rcount",  i, {16'd0, Redirect_count}, {16'd0, vecs[i].e_cnt});
      end

      for (int c = 0; c < 1500; c++) begin
         logic [31:0] e_pc, e_instr;
         bit          e_valid;
         reset        = ($urandom_range(0, 99) < 2);
         Redirect     = ($urandom_range(0, 99) < 10);
         RedirectAddr = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, IMEM_DEPTH*4 + 64);
         Instr_ready  = ($urandom_range(0, 99) < 60);
         step();
         e_valid = (mq.size() > 0);
         e_pc    = e_valid ? mq[0].pc : 32'd0;
         e_instr = e_valid ? mq[0].instr : 32'd0;
         chk("rnd_valid",   c, {31'd0, Instr_valid}, {31'd0, e_valid});
         chk("rnd_pc",      c, PC_current, e_pc);
         chk("rnd_instr",   c, Instr, e_instr);
         chk("rnd_pc_add4", c, PC_add4, e_valid ? e_pc + 32'd4 : 32'd0);
         chk("rnd_rcount",  c, {16'd0, Redirect_count}, {16'd0, m_cnt});
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
